adc_sample_avg: RTL

ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

---
 rtl/adc_sample_avg.sv | 134 +++++++++++++
 1 files changed

// File: rtl/adc_sample_avg.sv
// ---------------------------------------------------------------------------
// adc_sample_avg
// Moving-average filter for the raw ADC byte stream from the UART receiver.
// It keeps the last 2^DEPTH_LOG2 samples in a circular buffer and holds their
// running sum. Once that many samples are in the window, it emits the
// truncated average on every accepted sample. A separate idle counter flags
// the stream as stale when no sample has arrived for TIMEOUT_CLKS cycles.
//
// Parameters
//   DEPTH_LOG2   : log2 of the averaging window (3 -> 8 samples)
//   TIMEOUT_CLKS : idle clk cycles before o_Stale is raised
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high reset
//   i_Rx_DV    : one-cycle strobe, i_Rx_Byte is valid
//   i_Rx_Byte  : unsigned raw ADC code
//   o_Avg_DV   : one-cycle strobe, o_Avg_Byte was just updated
//   o_Avg_Byte : unsigned window average, held between strobes
//   o_Full     : window holds 2^DEPTH_LOG2 samples
//   o_Stale    : no sample seen for TIMEOUT_CLKS cycles
// ---------------------------------------------------------------------------
module adc_sample_avg #(
  parameter int DEPTH_LOG2   = 3,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Avg_DV,
  output logic [7:0] o_Avg_Byte,
  output logic       o_Full,
  output logic       o_Stale
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int SUM_W  = 8 + DEPTH_LOG2;
  localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [DEPTH_LOG2:0] FILL_LAST    = (DEPTH_LOG2 + 1)'(DEPTH - 1);
  localparam logic [IDLE_W-1:0]   TIMEOUT_VAL  = IDLE_W'(TIMEOUT_CLKS);

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } state_t;

  state_t                r_State;
  logic [7:0]            r_Buf [DEPTH];
  logic [DEPTH_LOG2-1:0] r_Wr_Ptr;
  logic [DEPTH_LOG2:0]   r_Fill_Cnt;
  logic [SUM_W-1:0]      r_Sum;
  logic [IDLE_W-1:0]     r_Idle_Cnt;

  logic [7:0]            w_Evicted;
  logic [SUM_W-1:0]      w_Sum_Next;
  logic [7:0]            w_Avg_Next;
  logic [IDLE_W-1:0]     w_Idle_Inc;
  logic                  w_Idle_Sat;

  // The sample being overwritten leaves the sum. While the window is still
  // filling, the slot holds no real sample, so it contributes zero. The sum
  // is computed as old - evicted + new. Intermediate wrap-around cancels out
  // because the final value always fits in SUM_W bits.
  always_comb begin
    w_Evicted  = (r_State == ST_RUN) ? r_Buf[r_Wr_Ptr] : 8'd0;
    w_Sum_Next = r_Sum - {{DEPTH_LOG2{1'b0}}, w_Evicted}
                       + {{DEPTH_LOG2{1'b0}}, i_Rx_Byte};
    w_Avg_Next = w_Sum_Next[SUM_W-1:DEPTH_LOG2];
    w_Idle_Inc = r_Idle_Cnt + 1'b1;
    w_Idle_Sat = (r_Idle_Cnt == TIMEOUT_VAL);
  end

  // Window datapath and FILL/RUN control. Every accepted sample is written and
  // the pointer advances in both states. The average strobe fires only when
  // the window is complete: on the accept that finishes filling, and on every
  // accept after that.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_Buf[i] <= 8'd0;
      end
      r_State    <= ST_FILL;
      r_Wr_Ptr   <= '0;
      r_Fill_Cnt <= '0;
      r_Sum      <= '0;
      o_Avg_DV   <= 1'b0;
      o_Avg_Byte <= 8'd0;
      o_Full     <= 1'b0;
    end else begin
      o_Avg_DV <= 1'b0;
      if (i_Rx_DV) begin
        r_Buf[r_Wr_Ptr] <= i_Rx_Byte;
        r_Wr_Ptr        <= r_Wr_Ptr + 1'b1;
        r_Sum           <= w_Sum_Next;
        case (r_State)
          ST_FILL: begin
            r_Fill_Cnt <= r_Fill_Cnt + 1'b1;
            if (r_Fill_Cnt == FILL_LAST) begin
              r_State    <= ST_RUN;
              o_Full     <= 1'b1;
              o_Avg_DV   <= 1'b1;
              o_Avg_Byte <= w_Avg_Next;
            end
          end
          ST_RUN: begin
            o_Avg_DV   <= 1'b1;
            o_Avg_Byte <= w_Avg_Next;
          end
          default: r_State <= ST_FILL;
        endcase
      end
    end
  end

  // Staleness watchdog. An accepted sample always wins: it clears the counter
  // and the flag, even on the cycle the count would have reached the limit.
  // Otherwise the counter climbs and saturates at the limit. The flag rises
  // on the same edge the counter reaches the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_Idle_Cnt <= '0;
      o_Stale    <= 1'b0;
    end else if (i_Rx_DV) begin
      r_Idle_Cnt <= '0;
      o_Stale    <= 1'b0;
    end else if (!w_Idle_Sat) begin
      r_Idle_Cnt <= w_Idle_Inc;
      o_Stale    <= (w_Idle_Inc == TIMEOUT_VAL);
    end
  end

endmodule
